mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous instruction/data RAM between the instruction-fetch requester (IF) and the load/store requester (LS).
- Per cycle: picks at most one requester, drives the RAM port from it, and returns read data one cycle later to the winner.
- Sits between the core pipeline and the unified RAM.
- Includes a starvation guard so IF cannot be locked out by a continuous LS stream.

Parameters:
- ADDR_W, 10, word-address width.
- DATA_W, 32, data width (multiple of 8).
- MAX_WAIT, 4, max consecutive cycles IF may be denied while requesting (>=1).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IF_REQ  in  1  IF read request.
- IF_ADDR  in  ADDR_W  IF word address.
- IF_GNT  out  1  IF request accepted this cycle.
- IF_RVALID  out  1  IF read data valid.
- IF_RDATA  out  DATA_W  IF read data.
- LS_REQ  in  1  LS request.
- LS_WE  in  1  1 = write, 0 = read.
- LS_BE  in  DATA_W/8  byte enables for writes.
- LS_ADDR  in  ADDR_W  LS word address.
- LS_WDATA  in  DATA_W  LS write data.
- LS_GNT  out  1  LS request accepted this cycle.
- LS_RVALID  out  1  LS read data valid.
- LS_RDATA  out  DATA_W  LS read data.
- RAM_EN  out  1  RAM access this cycle.
- RAM_WE  out  1  RAM write.
- RAM_BE  out  DATA_W/8  RAM byte enables.
- RAM_ADDR  out  ADDR_W  RAM address.
- RAM_WDATA  out  DATA_W  RAM write data.
- RAM_RDATA  in  DATA_W  RAM read data; valid exactly 1 cycle after a read with RAM_EN=1.

Behaviour:
- Grant is combinational from current requests and registered state. At most one of IF_GNT/LS_GNT is high per cycle.
- RAM_EN = IF_GNT | LS_GNT. RAM_* are muxed from the winner.
- When idle: RAM_WE=0, RAM_BE=0, RAM_ADDR=0, RAM_WDATA=0.
- IF accesses: RAM_WE=0, RAM_BE=all ones.
- Handshake: a requester holds REQ and its address/data stable until it sees GNT=1 in a cycle. The transaction is accepted on that rising edge. REQ may stay high for back-to-back accesses.
- Default priority is LS over IF.
- Starvation counter WAIT_CNT (width clog2(MAX_WAIT+1)):
  - Increments each cycle IF_REQ=1 and IF is not granted.
  - Clears when IF is granted or IF_REQ=0.
  - When WAIT_CNT==MAX_WAIT and IF_REQ=1, IF wins regardless of LS_REQ. LS sees LS_GNT=0 and must hold.
  - Saturates at MAX_WAIT.
- Response pipeline: register RESP_OWNER in {NONE, IF, LS} captures the winner of a granted read. Writes set NONE.
- Next cycle: the owner's xx_RVALID=1 and xx_RDATA=RAM_RDATA. The other RVALID stays 0.
- Read latency is 1 cycle from the grant edge.
- Back-to-back grants deliver one RVALID per cycle in grant order.
- RDATA outputs are 0 whenever the corresponding RVALID=0.
- LS writes produce no RVALID. The write completes at the grant edge.
- Simultaneous requests with WAIT_CNT<MAX_WAIT: LS wins, IF waits, counter increments.
- Only one request present: it is granted the same cycle.
- Reset, asynchronous, may assert at any time:
  - WAIT_CNT=0, RESP_OWNER=NONE.
  - All GNT/RVALID=0, all RDATA=0, RAM_EN=0.
  - An in-flight read response is discarded; no RVALID appears after reset deasserts.
- No internal FSM beyond the two registers; the design must hold with REQ toggling every cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- When defined:
  - Replaces fixed LS priority with round-robin.
  - A LAST_WIN register (reset = LS) records the last winner. On simultaneous requests the requester that is not LAST_WIN wins.
  - WAIT_CNT and the MAX_WAIT override are not instantiated; IF waits at most 1 cycle.
- When undefined: fixed LS priority plus the starvation guard described above.

Test Plan:
- Reset mid-read:
  - Stimulus: LS read addr 5 granted, RESET pulsed high in the next cycle.
  - Response: LS_RVALID never rises; all outputs 0 during reset.
- IF alone:
  - Stimulus: IF_REQ=1 for addr 0,1,2 on consecutive cycles.
  - Response: IF_GNT=1 each cycle; IF_RVALID=1 on cycles 2-4 with RAM contents of 0,1,2.
- LS write then read:
  - Stimulus: write 0xDEADBEEF BE=4'b0011 to addr 7 over prior 0x11223344, then read addr 7.
  - Response: LS_RDATA=0x1122BEEF one cycle after the read grant; no RVALID for the write.
- Contention, fixed priority:
  - Stimulus: IF_REQ and LS_REQ held continuously, MAX_WAIT=4.
  - Response: LS granted 4 cycles, IF granted on the 5th, pattern repeats; RVALIDs routed correctly.
- Simultaneous single requests:
  - Stimulus: IF_REQ=1 and LS_REQ=1 for one cycle only, LS dropping after its grant.
  - Response: LS_GNT in cycle 0, IF_GNT in cycle 1, IF_RVALID in cycle 2.
- ARB_ROUND_ROBIN_EN defined:
  - Stimulus: both requesters held high.
  - Response: grants alternate IF, LS, IF, LS starting with IF after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sync RAM between IF and LS.
// Fixed LS priority with IF starvation guard; ARB_ROUND_ROBIN_EN selects round-robin.
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   if_req/if_addr                 IF read request and word address
//   if_gnt/if_rvalid/if_rdata      IF accept, read response (data 0 when invalid)
//   ls_req/ls_we/ls_be             LS request, write flag, byte enables
//   ls_addr/ls_wdata               LS word address and write data
//   ls_gnt/ls_rvalid/ls_rdata      LS accept, read response (data 0 when invalid)
//   ram_en/ram_we/ram_be           RAM access strobe, write, byte enables
//   ram_addr/ram_wdata/ram_rdata   RAM address, write data, read data (1-cycle latency)
module mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } owner_t;

  owner_t resp_owner;
  logic   if_win;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {
    LAST_IF,
    LAST_LS
  } last_t;

  last_t last_win;

  // On contention the requester that did not win last time goes first.
  assign if_win = if_req & (~ls_req | (last_win == LAST_LS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_win <= LAST_LS;
    end else if (if_gnt) begin
      last_win <= LAST_IF;
    end else if (ls_gnt) begin
      last_win <= LAST_LS;
    end
  end
`else
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             starved;

  // Once IF has been denied MAX_WAIT cycles in a row it overrides LS.
  assign starved = (wait_cnt == CNT_W'(MAX_WAIT));
  assign if_win  = if_req & (~ls_req | starved);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      wait_cnt <= '0;
    end else if (!starved) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`endif

  // Grants are suppressed while reset is held.
  assign if_gnt = ~reset & if_win;
  assign ls_gnt = ~reset & ls_req & ~if_win;
  assign ram_en = if_gnt | ls_gnt;

  always_comb begin
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      if_gnt: begin
        ram_be   = {BE_W{1'b1}};
        ram_addr = if_addr;
      end
      ls_gnt: begin
        ram_we    = ls_we;
        ram_be    = ls_be;
        ram_addr  = ls_addr;
        ram_wdata = ls_wdata;
      end
      default: ;
    endcase
  end

  // Remembers who owns the read data the RAM returns next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_owner <= OWN_NONE;
    end else begin
      unique case (1'b1)
        if_gnt:          resp_owner <= OWN_IF;
        ls_gnt & ~ls_we: resp_owner <= OWN_LS;
        default:         resp_owner <= OWN_NONE;
      endcase
    end
  end

  assign if_rvalid = (resp_owner == OWN_IF);
  assign ls_rvalid = (resp_owner == OWN_LS);
  assign if_rdata  = if_rvalid ? ram_rdata : '0;
  assign ls_rdata  = ls_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with RAM device model.
// Predictor models grants from arbitration rules; monitor checks responses.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [BW-1:0] ls_be = '0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [BW-1:0] ram_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .ls_req(ls_req),
    .ls_we(ls_we),
    .ls_be(ls_be),
    .ls_addr(ls_addr),
    .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata),
    .ram_en(ram_en),
    .ram_we(ram_we),
    .ram_be(ram_be),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_ls;
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  resp_t         sb[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  logic [DW-1:0] ram[0:(1<<AW)-1];
  logic [DW-1:0] shadow[0:(1<<AW)-1];
  int            denied = 0;
  bit            last_ls = 1'b1;

  function automatic logic [DW-1:0] seed_val(int i);
    return (DW'(i) * 32'h9E37_79B1) ^ 32'h0F0F_0F0F;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = seed_val(i);
      shadow[i] = seed_val(i);
    end
  end

  // RAM device: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < BW; b++)
          if (ram_be[b]) ram[ram_addr][8*b+:8] <= ram_wdata[8*b+:8];
      end else begin
        ram_rdata <= ram[ram_addr];
      end
    end
  end

  // Predictor: who should win, what the RAM port shows, what comes back.
  always @(negedge clk) begin : predictor
    bit ei, el;
    if (reset) begin
      denied  = 0;
      last_ls = 1'b1;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      ei = if_req && (!ls_req || last_ls);
`else
      ei = if_req && (!ls_req || denied >= MW);
`endif
      el = ls_req && !ei;
      chk("if_gnt", if_gnt, ei);
      chk("ls_gnt", ls_gnt, el);
      chk("ram_en", ram_en, ei || el);
      if (ei) begin
        chk("ram_addr_if", ram_addr, if_addr);
        chk("ram_we_if", ram_we, 0);
        chk("ram_be_if", ram_be, {BW{1'b1}});
        sb.push_back('{1'b0, shadow[if_addr], cyc + 1});
      end else if (el) begin
        chk("ram_addr_ls", ram_addr, ls_addr);
        chk("ram_we_ls", ram_we, ls_we);
        if (ls_we) begin
          chk("ram_be_ls", ram_be, ls_be);
          chk("ram_wdata_ls", ram_wdata, ls_wdata);
          for (int b = 0; b < BW; b++)
            if (ls_be[b]) shadow[ls_addr][8*b+:8] = ls_wdata[8*b+:8];
        end else begin
          sb.push_back('{1'b1, shadow[ls_addr], cyc + 1});
        end
      end else begin
        chk("idle_we", ram_we, 0);
        chk("idle_be", ram_be, 0);
        chk("idle_addr", ram_addr, 0);
        chk("idle_wdata", ram_wdata, 0);
      end
      denied = (if_req && !ei) ? denied + 1 : 0;
      if (ei) last_ls = 1'b0;
      else if (el) last_ls = 1'b1;
    end
  end

  // Monitor: read responses must arrive exactly when and where expected.
  always @(negedge clk) begin : monitor
    bit            evi, evl;
    logic [DW-1:0] ed;
    evi = 1'b0;
    evl = 1'b0;
    ed  = '0;
    if (reset) begin
      sb.delete();
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_ls_gnt", ls_gnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_ls_rvalid", ls_rvalid, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_ls_rdata", ls_rdata, 0);
      chk("rst_ram_en", ram_en, 0);
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        ed  = sb[0].data;
        evi = !sb[0].is_ls;
        evl = sb[0].is_ls;
        void'(sb.pop_front());
      end
      chk("if_rvalid", if_rvalid, evi);
      chk("ls_rvalid", ls_rvalid, evl);
      chk("if_rdata", if_rdata, evi ? ed : '0);
      chk("ls_rdata", ls_rdata, evl ? ed : '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Honour the handshake: keep a request until it was granted.
  task automatic drive(int pif, int pls);
    bit gi, gl;
    @(negedge clk);
    gi = if_gnt;
    gl = ls_gnt;
    @(posedge clk);
    #1;
    if (!if_req || gi) begin
      if_req  = ($urandom_range(1, 100) <= pif);
      if_addr = AW'($urandom_range(0, 31));
    end
    if (!ls_req || gl) begin
      ls_req   = ($urandom_range(1, 100) <= pls);
      ls_we    = 1'($urandom);
      ls_be    = BW'($urandom);
      ls_addr  = AW'($urandom_range(0, 31));
      ls_wdata = $urandom;
    end
  endtask

  task automatic drain();
    for (int g = 0; g < 12 && (if_req || ls_req); g++) drive(0, 0);
  endtask

  initial begin
    int pi, pl;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset while an LS read response is in flight.
    step();
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = AW'(5);
    step();
    ls_req = 1'b0;
    reset  = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (3) step();

    // IF alone on addresses 0, 1, 2.
    if_req  = 1'b1;
    if_addr = AW'(0);
    step();
    if_addr = AW'(1);
    step();
    if_addr = AW'(2);
    step();
    if_req = 1'b0;
    repeat (2) step();

    // Byte-masked write merge, then read back.
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_be    = 4'hF;
    ls_addr  = AW'(7);
    ls_wdata = 32'h1122_3344;
    step();
    ls_be    = 4'b0011;
    ls_wdata = 32'hDEAD_BEEF;
    step();
    ls_we = 1'b0;
    step();
    ls_req = 1'b0;
    @(negedge clk);
    chk("wr_rd_valid", ls_rvalid, 1);
    chk("wr_rd_data", ls_rdata, 32'h1122_BEEF);

    // Sustained contention.
    if_req = 1'b1;
    ls_req = 1'b1;
    repeat (20) drive(100, 100);
    drain();

    // Both request once; each drops after its grant.
    step();
    if_req  = 1'b1;
    if_addr = AW'(3);
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = AW'(9);
    drain();
    repeat (2) step();

    // Randomised traffic with a reset pulse partway through.
    for (int blk = 0; blk < 15; blk++) begin
      pi = $urandom_range(0, 100);
      pl = $urandom_range(0, 100);
      repeat (200) drive(pi, pl);
      if (blk == 7) begin
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
      end
    end
    drain();
    repeat (3) step();
    @(negedge clk);
    chk("sb_empty", DW'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

endmodule
